// File: rtl/ysyx_23060332_wbu_pkg.sv
// Shared register-file widths and the commit-record type for the write-back unit.
// Uncomment YSYX_23060332_WBU_FWD_EN below to forward the commit register to IDU operands.
`ifndef YSYX_23060332_DEFINE_SV
`define YSYX_23060332_DEFINE_SV
`define RegAddrBus 4:0
`define RegDataBus 31:0
// `define YSYX_23060332_WBU_FWD_EN
`endif

package ysyx_23060332_wbu_pkg;

  localparam int REG_NUM = 32;

  typedef struct packed {
    logic               valid;
    logic               wen;
    logic [`RegAddrBus] rd;
    logic [`RegDataBus] data;
    logic [`RegDataBus] pc;
  } commit_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_EXU  = 2'd1,
    SRC_LSU  = 2'd2
  } src_e;

  // x0 is hard-wired, so a record targeting it never reaches the register file
  function automatic logic writes_reg(commit_t c);
    return c.valid && c.wen && (c.rd != '0);
  endfunction

endpackage

// File: rtl/ysyx_23060332_scoreboard.sv
// Busy vector of architectural registers with pending writes; set on issue, cleared on write-back.
module ysyx_23060332_scoreboard
  import ysyx_23060332_wbu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               set_en,
  input  logic [`RegAddrBus] set_rd,
  input  logic               clr_en,
  input  logic [`RegAddrBus] clr_rd,
  input  logic [`RegAddrBus] raddr1,
  input  logic [`RegAddrBus] raddr2,
  input  logic [`RegAddrBus] id_rd,
  output logic               busy1,
  output logic               busy2,
  output logic               busy_id
);

  logic [REG_NUM-1:0] busy;
  logic [REG_NUM-1:0] busy_next;

  // set applied after clear so a same-cycle issue keeps the register pending
  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_rd] = 1'b0;
    if (set_en) busy_next[set_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  assign busy1   = busy[raddr1];
  assign busy2   = busy[raddr2];
  assign busy_id = busy[id_rd];

endmodule

// File: rtl/ysyx_23060332_wbu.sv
// Write-back unit: LSU-over-EXU arbitration, one-entry commit register, RAW/WAW hazard detection.
// Optional forwarding from the commit register is enabled by YSYX_23060332_WBU_FWD_EN.
module ysyx_23060332_wbu
  import ysyx_23060332_wbu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               exu_valid,
  input  logic               exu_wen,
  input  logic [`RegAddrBus] exu_rd,
  input  logic [`RegDataBus] exu_wdata,
  input  logic [`RegDataBus] exu_pc,
  output logic               exu_ready,
  input  logic               lsu_valid,
  input  logic               lsu_wen,
  input  logic [`RegAddrBus] lsu_rd,
  input  logic [`RegDataBus] lsu_wdata,
  input  logic [`RegDataBus] lsu_pc,
  output logic               lsu_ready,
  input  logic               id_issue,
  input  logic [`RegAddrBus] id_rd,
  input  logic               id_rd_wen,
  input  logic [`RegAddrBus] raddr1,
  input  logic [`RegAddrBus] raddr2,
  output logic               hazard,
  output logic               fwd1_hit,
  output logic               fwd2_hit,
  output logic [`RegDataBus] fwd1_data,
  output logic [`RegDataBus] fwd2_data,
  output logic [`RegAddrBus] waddr,
  output logic [`RegDataBus] wdata,
  output logic               reg_wen,
  output logic               commit_valid,
  output logic [`RegDataBus] commit_pc
);

  src_e    src;
  commit_t commit_p0;
  commit_t commit_p1;
  logic    wr_p1;
  logic    busy1;
  logic    busy2;
  logic    busy_id;
  logic    set_en;

  assign lsu_ready = 1'b1;
  assign exu_ready = !lsu_valid;

  always_comb begin
    src = SRC_NONE;
    if (lsu_valid)      src = SRC_LSU;
    else if (exu_valid) src = SRC_EXU;
  end

  always_comb begin
    commit_p0 = '0;
    case (src)
      SRC_LSU: commit_p0 = '{valid: 1'b1, wen: lsu_wen, rd: lsu_rd, data: lsu_wdata, pc: lsu_pc};
      SRC_EXU: commit_p0 = '{valid: 1'b1, wen: exu_wen, rd: exu_rd, data: exu_wdata, pc: exu_pc};
      default: commit_p0 = '0;
    endcase
  end

  // ---- p0 -> p1: accepted result enters the commit register, drained every cycle ----
  always_ff @(posedge clk) begin
    if (rst) commit_p1 <= '0;
    else     commit_p1 <= commit_p0;
  end

  // an entry still held while reset is asserted is discarded rather than written
  assign wr_p1        = writes_reg(commit_p1) && !rst;
  assign reg_wen      = wr_p1;
  assign waddr        = commit_p1.rd;
  assign wdata        = commit_p1.data;
  assign commit_valid = commit_p1.valid && !rst;
  assign commit_pc    = commit_p1.pc;

`ifdef YSYX_23060332_WBU_FWD_EN
  assign fwd1_hit  = writes_reg(commit_p1) && (commit_p1.rd == raddr1);
  assign fwd2_hit  = writes_reg(commit_p1) && (commit_p1.rd == raddr2);
  assign fwd1_data = commit_p1.data;
  assign fwd2_data = commit_p1.data;
`else
  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif

  assign hazard = (busy1 && !fwd1_hit) || (busy2 && !fwd2_hit) ||
                  (id_issue && id_rd_wen && busy_id);
  assign set_en = id_issue && id_rd_wen && (id_rd != '0) && !hazard;

  ysyx_23060332_scoreboard u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (set_en),
    .set_rd  (id_rd),
    .clr_en  (wr_p1),
    .clr_rd  (commit_p1.rd),
    .raddr1  (raddr1),
    .raddr2  (raddr2),
    .id_rd   (id_rd),
    .busy1   (busy1),
    .busy2   (busy2),
    .busy_id (busy_id)
  );

endmodule
